// File: rtl/bram_sync_tdp_be.sv
// Single-clock true-dual-port block RAM with byte write enables, selectable
// read-during-write behaviour, optional output register and clear-on-reset.
module bram_sync_tdp_be #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 4,
   parameter int BYTE_WIDTH   = 8,
   parameter int WRITE_MODE   = 0,
   parameter int OUT_REG      = 0,
   parameter int CLEAR_ON_RST = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   output logic                             init_busy,
   output logic                             collision,
   input  logic                             a_wr,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_be,
   input  logic [ADDR_WIDTH-1:0]            a_addr,
   input  logic [DATA_WIDTH-1:0]            a_data_in,
   output logic [DATA_WIDTH-1:0]            a_data_out,
   output logic                             a_rd_valid,
   input  logic                             b_wr,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_be,
   input  logic [ADDR_WIDTH-1:0]            b_addr,
   input  logic [DATA_WIDTH-1:0]            b_data_in,
   output logic [DATA_WIDTH-1:0]            b_data_out,
   output logic                             b_rd_valid
);

   localparam int NB             = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH          = 2 ** ADDR_WIDTH;
   localparam int WM_WRITE_FIRST = 0;
   localparam int WM_READ_FIRST  = 1;
   localparam int WM_NO_CHANGE   = 2;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_CLEAR = 1'b1} state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [ADDR_WIDTH-1:0]   clr_cnt_r;
   logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
   logic                    busy_s;
   logic                    clr_we_s;
   logic                    acc_s;
   logic                    same_addr_s;
   logic                    collision_s;
   logic [NB-1:0]           a_cross_be_s;
   logic [NB-1:0]           b_cross_be_s;
   logic [DATA_WIDTH-1:0]   a_old_s;
   logic [DATA_WIDTH-1:0]   b_old_s;
   logic [DATA_WIDTH-1:0]   a_final_s;
   logic [DATA_WIDTH-1:0]   b_final_s;
   logic [DATA_WIDTH-1:0]   a_d1_r;
   logic [DATA_WIDTH-1:0]   b_d1_r;
   logic                    a_v1_r;
   logic                    b_v1_r;
   logic                    col1_r;

   // Overlay the enabled byte lanes of wdata onto base.
   function automatic logic [DATA_WIDTH-1:0] byte_merge(
      input logic [DATA_WIDTH-1:0] base,
      input logic [DATA_WIDTH-1:0] wdata,
      input logic [NB-1:0]         be
   );
      logic [DATA_WIDTH-1:0] res;
      res = base;
      for (int k = 0; k < NB; k++) begin
         res[k*BYTE_WIDTH +: BYTE_WIDTH] = be[k] ? wdata[k*BYTE_WIDTH +: BYTE_WIDTH]
                                                 : base[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
      return res;
   endfunction

   // Port result {valid, data} for one access, given the read-during-write mode.
   function automatic logic [DATA_WIDTH:0] port_result(
      input logic                  wr,
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [DATA_WIDTH-1:0] held_word
   );
      logic [DATA_WIDTH:0] res;
      if (!wr) begin
         res = {1'b1, old_word};
      end else begin
         case (WRITE_MODE)
            WM_WRITE_FIRST: res = {1'b1, new_word};
            WM_READ_FIRST:  res = {1'b1, old_word};
            WM_NO_CHANGE:   res = {1'b0, held_word};
            default:        res = {1'b1, new_word};
         endcase
      end
      return res;
   endfunction

   // Clear FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Clear FSM next state: leave CLEAR once the last word has been zeroed.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_RUN:   state_nxt_s = ST_RUN;
         ST_CLEAR: begin
            if (clr_cnt_r == LAST_ADDR) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_CLEAR;
            end
         end
         default:  state_nxt_s = ST_RUN;
      endcase
   end

   // Clear FSM outputs: busy flag, clear write strobe and port access qualifier.
   always_comb begin
      busy_s   = 1'b0;
      clr_we_s = 1'b0;
      acc_s    = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            busy_s   = 1'b1;
            clr_we_s = ~rst;
         end
         ST_RUN:   acc_s = en & ~rst;
         default:  busy_s = 1'b0;
      endcase
   end

   assign init_busy = busy_s;

   // Clear address counter; wraps back to zero as the sequence finishes.
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_cnt_r <= '0;
      end else if (state_r == ST_CLEAR) begin
         clr_cnt_r <= clr_cnt_r + 1'b1;
      end else begin
         clr_cnt_r <= clr_cnt_r;
      end
   end

   // On a same-address write/write, both ports compute the identical final
   // word (A lanes first, B lanes on top) so either write lands the same value.
   assign same_addr_s  = (a_addr == b_addr);
   assign a_cross_be_s = (a_wr && same_addr_s) ? a_be : '0;
   assign b_cross_be_s = (b_wr && same_addr_s) ? b_be : '0;
   assign a_old_s      = mem_r[a_addr];
   assign b_old_s      = mem_r[b_addr];
   assign a_final_s    = byte_merge(byte_merge(a_old_s, a_data_in, a_be), b_data_in, b_cross_be_s);
   assign b_final_s    = byte_merge(byte_merge(b_old_s, a_data_in, a_cross_be_s), b_data_in, b_be);
   assign collision_s  = acc_s & same_addr_s & (a_wr | b_wr);

   // Storage array: clear sequencer or port writes; contents are not reset.
   always_ff @(posedge clk) begin
      if (clr_we_s) begin
         mem_r[clr_cnt_r] <= '0;
      end else if (acc_s) begin
         if (a_wr) begin
            mem_r[a_addr] <= a_final_s;
         end
         if (b_wr) begin
            mem_r[b_addr] <= b_final_s;
         end
      end
   end

   // First output stage: port results and collision flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_d1_r <= '0;
         b_d1_r <= '0;
         a_v1_r <= 1'b0;
         b_v1_r <= 1'b0;
         col1_r <= 1'b0;
      end else if (busy_s) begin
         a_v1_r <= 1'b0;
         b_v1_r <= 1'b0;
         col1_r <= 1'b0;
      end else if (acc_s) begin
         {a_v1_r, a_d1_r} <= port_result(a_wr, a_old_s, a_final_s, a_d1_r);
         {b_v1_r, b_d1_r} <= port_result(b_wr, b_old_s, b_final_s, b_d1_r);
         col1_r           <= collision_s;
      end else begin
         a_v1_r <= a_v1_r;
         b_v1_r <= b_v1_r;
         col1_r <= col1_r;
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] a_d2_r;
      logic [DATA_WIDTH-1:0] b_d2_r;
      logic                  a_v2_r;
      logic                  b_v2_r;
      logic                  col2_r;

      // Second output stage follows the first on every enabled or clearing cycle.
      always_ff @(posedge clk) begin
         if (rst) begin
            a_d2_r <= '0;
            b_d2_r <= '0;
            a_v2_r <= 1'b0;
            b_v2_r <= 1'b0;
            col2_r <= 1'b0;
         end else if (busy_s || acc_s) begin
            a_d2_r <= a_d1_r;
            b_d2_r <= b_d1_r;
            a_v2_r <= a_v1_r;
            b_v2_r <= b_v1_r;
            col2_r <= col1_r;
         end else begin
            a_d2_r <= a_d2_r;
            b_d2_r <= b_d2_r;
            a_v2_r <= a_v2_r;
            b_v2_r <= b_v2_r;
            col2_r <= col2_r;
         end
      end

      assign a_data_out = a_d2_r;
      assign b_data_out = b_d2_r;
      assign a_rd_valid = a_v2_r;
      assign b_rd_valid = b_v2_r;
      assign collision  = col2_r;
   end else begin : g_no_out_reg
      assign a_data_out = a_d1_r;
      assign b_data_out = b_d1_r;
      assign a_rd_valid = a_v1_r;
      assign b_rd_valid = b_v1_r;
      assign collision  = col1_r;
   end

endmodule

// File: tb/tb_bram_sync_tdp_be.sv
// Bench for bram_sync_tdp_be: four instances (write-first, read-first, no-change,
// write-first with output register) share one stimulus stream.
module tb_bram_sync_tdp_be;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             a_wr, b_wr;
   logic [3:0]       a_be, b_be;
   logic [3:0]       a_addr, b_addr;
   logic [31:0]      a_din, b_din;
   logic [3:0][31:0] a_do, b_do;
   logic [3:0]       a_v, b_v, col, busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      bram_sync_tdp_be #(
         .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
         .WRITE_MODE((g == 2) ? 2 : ((g == 1) ? 1 : 0)),
         .OUT_REG((g == 3) ? 1 : 0), .CLEAR_ON_RST(1)
      ) u_dut (
         .clk(clk), .rst(rst), .en(en), .init_busy(busy[g]), .collision(col[g]),
         .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_data_in(a_din),
         .a_data_out(a_do[g]), .a_rd_valid(a_v[g]),
         .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_data_in(b_din),
         .b_data_out(b_do[g]), .b_rd_valid(b_v[g])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en = 1'b1; a_wr = 1'b0; b_wr = 1'b0; a_be = 4'h0; b_be = 4'h0;
      a_addr = 4'h0; b_addr = 4'h0; a_din = 32'h0; b_din = 32'h0;
   endtask

   task automatic test_reset();
      int n;
      idle();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if (busy !== 4'hF || a_v !== 4'h0 || b_v !== 4'h0 || col !== 4'h0 || a_do[0] !== 32'h0) begin
         failures++;
         $display("FAIL reset_state busy=%b a_v=%b b_v=%b col=%b a_do=%h expected busy=1111 rest 0",
                  busy, a_v, b_v, col, a_do[0]);
      end
      rst = 1'b0;
      n = 0;
      while (busy[0] && n < 40) begin tick(); n++; end
      checks++;
      if (n !== 16) begin
         failures++;
         $display("FAIL clear_length got=%0d expected=16", n);
      end
      for (int i = 0; i < 16; i++) begin
         a_addr = 4'(i);
         tick();
         checks++;
         if (a_do[0] !== 32'h0 || a_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL cleared_read addr=%0d got=%h v=%b expected=00000000 v=1", i, a_do[0], a_v[0]);
         end
      end
   endtask

   task automatic test_write_first();
      idle();
      a_wr = 1'b1; a_addr = 4'd2; a_be = 4'hF; a_din = 32'hDEADBEEF;
      tick();
      checks++;
      if (a_do[0] !== 32'hDEADBEEF || a_v[0] !== 1'b1) begin
         failures++;
         $display("FAIL wf_full_write got=%h v=%b expected=deadbeef v=1", a_do[0], a_v[0]);
      end
      a_be = 4'b0101; a_din = 32'h11223344;
      tick();
      checks++;
      if (a_do[0] !== 32'hDE22BE44) begin
         failures++;
         $display("FAIL wf_byte_write got=%h expected=de22be44", a_do[0]);
      end
      checks++;
      if (a_do[1] !== 32'hDEADBEEF || a_v[1] !== 1'b1) begin
         failures++;
         $display("FAIL rf_byte_write got=%h v=%b expected=deadbeef v=1", a_do[1], a_v[1]);
      end
      checks++;
      if (a_do[2] !== 32'h0 || a_v[2] !== 1'b0) begin
         failures++;
         $display("FAIL nc_byte_write got=%h v=%b expected=00000000 v=0", a_do[2], a_v[2]);
      end
      idle();
      b_addr = 4'd2;
      tick();
      checks++;
      if (b_do[0] !== 32'hDE22BE44 || b_v[0] !== 1'b1) begin
         failures++;
         $display("FAIL b_readback got=%h v=%b expected=de22be44 v=1", b_do[0], b_v[0]);
      end
   endtask

   task automatic test_rw_modes();
      idle();
      a_wr = 1'b1; a_addr = 4'd5; a_be = 4'hF; a_din = 32'h12345678;
      tick();
      idle();
      a_addr = 4'd2;
      tick();
      checks++;
      if (a_do[2] !== 32'hDE22BE44 || a_v[2] !== 1'b1) begin
         failures++;
         $display("FAIL nc_read got=%h v=%b expected=de22be44 v=1", a_do[2], a_v[2]);
      end
      a_wr = 1'b1; a_addr = 4'd5; a_be = 4'hF; a_din = 32'hCAFEF00D;
      tick();
      checks++;
      if (a_do[1] !== 32'h12345678 || a_v[1] !== 1'b1) begin
         failures++;
         $display("FAIL read_first got=%h v=%b expected=12345678 v=1", a_do[1], a_v[1]);
      end
      checks++;
      if (a_do[2] !== 32'hDE22BE44 || a_v[2] !== 1'b0) begin
         failures++;
         $display("FAIL no_change got=%h v=%b expected=de22be44 v=0", a_do[2], a_v[2]);
      end
      checks++;
      if (a_do[0] !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL write_first_overwrite got=%h expected=cafef00d", a_do[0]);
      end
   endtask

   task automatic test_collision();
      idle();
      a_wr = 1'b1; a_addr = 4'd7; a_be = 4'b1100; a_din = 32'hAAAAAAAA;
      b_wr = 1'b1; b_addr = 4'd7; b_be = 4'b0110; b_din = 32'h55555555;
      tick();
      checks++;
      if (col[0] !== 1'b1 || col[3] !== 1'b0) begin
         failures++;
         $display("FAIL collision_flag got=%b/%b expected=1/0", col[0], col[3]);
      end
      checks++;
      if (a_do[0] !== 32'hAA555500 || b_do[0] !== 32'hAA555500) begin
         failures++;
         $display("FAIL collision_word a=%h b=%h expected=aa555500", a_do[0], b_do[0]);
      end
      idle();
      a_addr = 4'd7; b_addr = 4'd7;
      tick();
      checks++;
      if (col[0] !== 1'b0 || a_do[0] !== 32'hAA555500) begin
         failures++;
         $display("FAIL read_read col=%b data=%h expected col=0 data=aa555500", col[0], a_do[0]);
      end
      checks++;
      if (col[3] !== 1'b1 || a_do[3] !== 32'hAA555500) begin
         failures++;
         $display("FAIL collision_outreg col=%b data=%h expected col=1 data=aa555500", col[3], a_do[3]);
      end
   endtask

   task automatic test_out_reg();
      logic [31:0] exp_q [3] = '{32'd1, 32'd2, 32'd2};
      idle();
      a_wr = 1'b1; a_addr = 4'd1; a_be = 4'hF; a_din = 32'd1;
      b_wr = 1'b1; b_addr = 4'd2; b_be = 4'hF; b_din = 32'd2;
      tick();
      idle();
      a_wr = 1'b1; a_addr = 4'd3; a_be = 4'hF; a_din = 32'd3;
      tick();
      idle();
      a_addr = 4'd1;
      tick();
      for (int i = 0; i < 3; i++) begin
         if (i < 2) a_addr = 4'(i + 2);
         else begin en = 1'b0; a_addr = 4'd0; end
         tick();
         checks++;
         if (a_do[3] !== exp_q[i] || a_v[3] !== 1'b1) begin
            failures++;
            $display("FAIL outreg_pipe step=%0d got=%h v=%b expected=%h v=1", i, a_do[3], a_v[3], exp_q[i]);
         end
      end
      checks++;
      if (a_do[0] !== 32'd3) begin
         failures++;
         $display("FAIL en_hold got=%h expected=00000003", a_do[0]);
      end
      en = 1'b1;
      tick();
      checks++;
      if (a_do[3] !== 32'd3) begin
         failures++;
         $display("FAIL outreg_resume got=%h expected=00000003", a_do[3]);
      end
   endtask

   task automatic test_rst_midclear();
      int n;
      idle();
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (9) tick();
      rst = 1'b1; tick();
      checks++;
      if (busy[0] !== 1'b1) begin
         failures++;
         $display("FAIL midclear_busy got=%b expected=1", busy[0]);
      end
      rst = 1'b0;
      n = 0;
      while (busy[0] && n < 40) begin tick(); n++; end
      checks++;
      if (n !== 16) begin
         failures++;
         $display("FAIL midclear_length got=%0d expected=16", n);
      end
      a_addr = 4'd7;
      tick();
      checks++;
      if (a_do[0] !== 32'h0) begin
         failures++;
         $display("FAIL midclear_content got=%h expected=00000000", a_do[0]);
      end
   endtask

   task automatic test_random();
      logic [31:0] m [16];
      logic [31:0] md [4][2];
      logic        mv [4][2];
      logic        mc [4];
      logic [31:0] od [2];
      logic        ov [2];
      logic        oc;
      logic [31:0] old_w [2];
      logic [3:0]  addr_p [2];
      logic        wr_p [2];
      logic [31:0] ed [2];
      logic        ev [2];
      logic        ec;
      int          n;
      idle();
      rst = 1'b1; tick(); rst = 1'b0;
      n = 0;
      while (busy[0] && n < 40) begin tick(); n++; end
      for (int i = 0; i < 16; i++) m[i] = 32'h0;
      for (int i = 0; i < 4; i++) begin
         md[i][0] = 32'h0; md[i][1] = 32'h0; mv[i][0] = 1'b0; mv[i][1] = 1'b0; mc[i] = 1'b0;
      end
      od[0] = 32'h0; od[1] = 32'h0; ov[0] = 1'b0; ov[1] = 1'b0; oc = 1'b0;
      repeat (400) begin
         en = ($urandom_range(0, 9) != 0);
         a_wr = 1'($urandom_range(0, 1)); b_wr = 1'($urandom_range(0, 1));
         a_addr = 4'($urandom_range(0, 3)); b_addr = 4'($urandom_range(0, 3));
         a_be = 4'($urandom); b_be = 4'($urandom);
         a_din = $urandom; b_din = $urandom;
         if (en) begin
            wr_p[0] = a_wr; wr_p[1] = b_wr; addr_p[0] = a_addr; addr_p[1] = b_addr;
            old_w[0] = m[a_addr]; old_w[1] = m[b_addr];
            for (int k = 0; k < 4; k++) if (a_wr && a_be[k]) m[a_addr][8*k +: 8] = a_din[8*k +: 8];
            for (int k = 0; k < 4; k++) if (b_wr && b_be[k]) m[b_addr][8*k +: 8] = b_din[8*k +: 8];
            od = md[3]; ov = mv[3]; oc = mc[3];
            for (int i = 0; i < 4; i++) begin
               for (int p = 0; p < 2; p++) begin
                  if (!wr_p[p]) begin md[i][p] = old_w[p]; mv[i][p] = 1'b1; end
                  else if (i == 1) begin md[i][p] = old_w[p]; mv[i][p] = 1'b1; end
                  else if (i == 2) mv[i][p] = 1'b0;
                  else begin md[i][p] = m[addr_p[p]]; mv[i][p] = 1'b1; end
               end
               mc[i] = (a_addr == b_addr) && (a_wr || b_wr);
            end
         end
         tick();
         for (int i = 0; i < 4; i++) begin
            if (i == 3) begin ed = od; ev = ov; ec = oc; end
            else begin ed = md[i]; ev = mv[i]; ec = mc[i]; end
            checks++;
            if (a_do[i] !== ed[0] || a_v[i] !== ev[0]) begin
               failures++;
               $display("FAIL rand_port_a dut=%0d got=%h v=%b expected=%h v=%b", i, a_do[i], a_v[i], ed[0], ev[0]);
            end
            checks++;
            if (b_do[i] !== ed[1] || b_v[i] !== ev[1]) begin
               failures++;
               $display("FAIL rand_port_b dut=%0d got=%h v=%b expected=%h v=%b", i, b_do[i], b_v[i], ed[1], ev[1]);
            end
            checks++;
            if (col[i] !== ec) begin
               failures++;
               $display("FAIL rand_collision dut=%0d got=%b expected=%b", i, col[i], ec);
            end
         end
      end
      idle();
      for (int i = 0; i < 16; i++) begin
         a_addr = 4'(i);
         tick();
         checks++;
         if (a_do[0] !== m[i]) begin
            failures++;
            $display("FAIL rand_readback addr=%0d got=%h expected=%h", i, a_do[0], m[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_first();
      test_rw_modes();
      test_collision();
      test_out_reg();
      test_rst_midclear();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
